// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares one AXI read address/data channel pair between the instruction-fetch
// and data-access SRAM-like read ports. One AR is issued per grant. Inst reads
// carry ARID 0 and data reads carry ARID 1. R beats are routed back by RID.
// The number of outstanding reads is tracked separately for each ID.
//
// Parameter:
//   OUT_DEPTH       maximum outstanding reads per ID (1..3)
//
// Ports:
//   clk, resetn                   clock, asynchronous active-low reset
//   inst_req/addr/size            inst read request (size 0=byte,1=half,2=word)
//   inst_addr_ok                  inst request accepted this cycle
//   inst_data_ok, inst_rdata      inst read data return
//   data_*                        same for the data port
//   wr_pend_valid, wr_pend_addr   a write to this address awaits its B response
//   arid/araddr/arsize/arvalid    AXI AR channel (master side)
//   arready                       AXI AR ready
//   rid/rdata/rvalid              AXI R channel
//   rready                        AXI R ready (1 from the first cycle out of reset)
//
// Configuration:
//   AXI_RD_RAW_CHECK_EN  when defined, a data read to the same 32-bit word as
//                        the pending write is held off until wr_pend_valid
//                        drops. When undefined, the wr_pend_* inputs are ignored.
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int unsigned OUT_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        wr_pend_valid,
    input  logic [31:0] wr_pend_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [1:0] DEPTH = 2'(OUT_DEPTH);

    typedef enum logic {
        IDLE    = 1'b0,
        AR_BUSY = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        rready_q;
    logic [1:0]  cnt_i_q, cnt_i_d;
    logic [1:0]  cnt_d_q, cnt_d_d;
    logic [3:0]  arid_q;
    logic [31:0] araddr_q;
    logic [1:0]  arsize_q;

    logic        raw_block;
    logic        grant_i, grant_d;
    logic        beat_i, beat_d;

`ifdef AXI_RD_RAW_CHECK_EN
    // Compare word addresses only: any byte of a word with a pending write blocks.
    assign raw_block = wr_pend_valid && (wr_pend_addr[31:2] == data_addr[31:2]);
    logic unused_wr_lsb;
    assign unused_wr_lsb = ^wr_pend_addr[1:0];
`else
    assign raw_block = 1'b0;
    logic unused_wr_pend;
    assign unused_wr_pend = ^{wr_pend_valid, wr_pend_addr};
`endif

    // rready_q doubles as an "out of reset" flag. No grant is made while the
    // block is still in reset.
    assign grant_d = (state_q == IDLE) && rready_q && data_req
                     && (cnt_d_q < DEPTH) && !raw_block;
    assign grant_i = (state_q == IDLE) && rready_q && !grant_d && inst_req
                     && (cnt_i_q < DEPTH);

    // Beats with any RID other than 0/1 are still consumed (rready=1). They touch nothing.
    assign beat_i = rvalid && rready_q && (rid == 4'd0);
    assign beat_d = rvalid && rready_q && (rid == 4'd1);

    // ---------------------------------------------------------------- state reg
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together from pre-edge values, and simulation order does not matter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------- next state
    // NOTE: every combinational output gets a default before the case. This
    // keeps paths that assign nothing from inferring a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_i || grant_d) state_d = AR_BUSY;
            AR_BUSY: if (arready)            state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        arvalid      = (state_q == AR_BUSY);
        inst_addr_ok = grant_i;
        data_addr_ok = grant_d;
    end

    assign arid         = arid_q;
    assign araddr       = araddr_q;
    assign arsize       = {1'b0, arsize_q};
    assign rready       = rready_q;
    assign inst_data_ok = beat_i;
    assign data_data_ok = beat_d;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    // ------------------------------------------------- AR fields and R ready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arid_q   <= 4'd0;
            araddr_q <= 32'd0;
            arsize_q <= 2'd0;
            rready_q <= 1'b0;
        end else begin
            rready_q <= 1'b1;
            if (grant_d) begin
                arid_q   <= 4'd1;
                araddr_q <= data_addr;
                arsize_q <= data_size;
            end else if (grant_i) begin
                arid_q   <= 4'd0;
                araddr_q <= inst_addr;
                arsize_q <= inst_size;
            end
        end
    end

    // --------------------------------------------------- outstanding counters
    // A grant and a returning beat in the same cycle cancel each other.
    // A decrement at zero stays at zero.
    function automatic logic [1:0] next_cnt(input logic [1:0] cnt,
                                            input logic       inc,
                                            input logic       dec);
        logic [1:0] res;
        res = cnt;
        case ({inc, dec})
            2'b10:   res = cnt + 2'd1;
            2'b01:   res = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

    always_comb begin
        cnt_i_d = next_cnt(cnt_i_q, grant_i, beat_i);
        cnt_d_d = next_cnt(cnt_d_q, grant_d, beat_d);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_i_q <= 2'd0;
            cnt_d_q <= 2'd0;
        end else begin
            cnt_i_q <= cnt_i_d;
            cnt_d_q <= cnt_d_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Scoreboard bench for axi_rd_arbiter. Each stimulus cycle is driven at
// negedge. A transaction-level model runs alongside it. The model tracks a
// busy AR slot, outstanding counts per ID, and in-order queues of issued reads.
// It pushes the expected per-cycle handshakes, the expected AR payloads and
// the expected read data into queues. A separate monitor pops these queues
// and compares them with what the DUT presents.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, data_req;
    logic [31:0] inst_addr, data_addr;
    logic [1:0]  inst_size, data_size;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        wr_pend_valid;
    logic [31:0] wr_pend_addr;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid, rready;

    axi_rd_arbiter #(.OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .wr_pend_valid(wr_pend_valid), .wr_pend_addr(wr_pend_addr),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
    } req_t;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [1:0]  size;
    } ar_t;

    typedef struct {
        bit          i_aok, d_aok, arv, i_dok, d_dok;
        ar_t         ar;
    } cyc_t;

    int checks = 0;
    int errors = 0;

    // Model state
    bit   m_busy;
    ar_t  m_cur_ar;
    req_t m_cur_req;
    int   m_out_i, m_out_d;
    req_t issued_i[$];
    req_t issued_d[$];

    // Requester state
    bit   i_pend, d_pend;
    req_t i_r, d_r;
    bit   wrp_v;
    logic [31:0] wrp_a;

    // Scoreboard queues
    cyc_t        exp_q[$];
    ar_t         ar_q[$];
    logic [31:0] rd_exp_i[$];
    logic [31:0] rd_exp_d[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic new_i(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        i_r.addr = a; i_r.size = s; i_r.data = d; i_pend = 1'b1;
    endtask

    task automatic new_d(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        d_r.addr = a; d_r.size = s; d_r.data = d; d_pend = 1'b1;
    endtask

    // One clock of stimulus plus a model step.
    // r_sel: -1 no beat, 0/1 return the oldest issued read of that ID,
    // >=2 a spurious beat carrying that RID.
    task automatic cycle(input bit ar_rdy, input int r_sel);
        bit          gi, gd, raw, bv;
        int          bid;
        logic [31:0] bdata;
        req_t        rr;
        cyc_t        e;
        @(negedge clk);
        inst_req  = i_pend; inst_addr = i_r.addr; inst_size = i_r.size;
        data_req  = d_pend; data_addr = d_r.addr; data_size = d_r.size;
        wr_pend_valid = wrp_v; wr_pend_addr = wrp_a;
        arready = ar_rdy;
        bv = 1'b0; bid = 0; bdata = $urandom;
        if (r_sel == 0 && issued_i.size() > 0) begin
            rr = issued_i.pop_front(); bv = 1'b1; bid = 0; bdata = rr.data;
        end else if (r_sel == 1 && issued_d.size() > 0) begin
            rr = issued_d.pop_front(); bv = 1'b1; bid = 1; bdata = rr.data;
        end else if (r_sel >= 2) begin
            bv = 1'b1; bid = r_sel;
        end
        rvalid = bv; rid = 4'(bid); rdata = bdata;

        raw = 1'b0;
`ifdef AXI_RD_RAW_CHECK_EN
        raw = wrp_v && (wrp_a[31:2] == d_r.addr[31:2]);
`endif
        gd = !m_busy && d_pend && (m_out_d < DEPTH) && !raw;
        gi = !m_busy && !gd && i_pend && (m_out_i < DEPTH);

        e.i_aok = gi; e.d_aok = gd; e.arv = m_busy; e.ar = m_cur_ar;
        e.i_dok = bv && bid == 0;
        e.d_dok = bv && bid == 1;
        exp_q.push_back(e);

        if (m_busy && ar_rdy) begin
            m_busy = 1'b0;
            if (m_cur_ar.id == 0) issued_i.push_back(m_cur_req);
            else                  issued_d.push_back(m_cur_req);
        end
        if (gd) begin
            m_cur_ar = '{1, d_r.addr, d_r.size};
            m_cur_req = d_r; m_busy = 1'b1; m_out_d++; d_pend = 1'b0;
            ar_q.push_back(m_cur_ar); rd_exp_d.push_back(d_r.data);
        end else if (gi) begin
            m_cur_ar = '{0, i_r.addr, i_r.size};
            m_cur_req = i_r; m_busy = 1'b1; m_out_i++; i_pend = 1'b0;
            ar_q.push_back(m_cur_ar); rd_exp_i.push_back(i_r.data);
        end
        if (bv && bid == 0 && m_out_i > 0) m_out_i--;
        if (bv && bid == 1 && m_out_d > 0) m_out_d--;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (!m_busy && issued_i.size() == 0 && issued_d.size() == 0 && !i_pend && !d_pend) break;
            cycle(1'b1, issued_i.size() > 0 ? 0 : (issued_d.size() > 0 ? 1 : -1));
        end
    endtask

    task automatic model_clear();
        m_busy = 1'b0; m_out_i = 0; m_out_d = 0;
        issued_i.delete(); issued_d.delete();
        ar_q.delete(); rd_exp_i.delete(); rd_exp_d.delete(); exp_q.delete();
        i_pend = 1'b0; d_pend = 1'b0;
        inst_req = 1'b0; data_req = 1'b0; arready = 1'b0; rvalid = 1'b0;
    endtask

    // ------------------------------------------------------------- monitor
    initial begin : monitor
        cyc_t e;
        ar_t  a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("inst_addr_ok", inst_addr_ok, e.i_aok);
                check("data_addr_ok", data_addr_ok, e.d_aok);
                check("arvalid", arvalid, e.arv);
                check("inst_data_ok", inst_data_ok, e.i_dok);
                check("data_data_ok", data_data_ok, e.d_dok);
                check("rready", rready, 1);
                if (e.arv) begin
                    check("arid_hold", arid, e.ar.id);
                    check("araddr_hold", araddr, e.ar.addr);
                    check("arsize_hold", arsize, {1'b0, e.ar.size});
                end
                if (arvalid && arready) begin
                    check("ar_q_nonempty", ar_q.size() > 0, 1);
                    if (ar_q.size() > 0) begin
                        a = ar_q.pop_front();
                        check("ar_hs_arid", arid, a.id);
                        check("ar_hs_araddr", araddr, a.addr);
                        check("ar_hs_arsize", arsize, {1'b0, a.size});
                    end
                end
                if (inst_data_ok) begin
                    check("rd_exp_i_nonempty", rd_exp_i.size() > 0, 1);
                    if (rd_exp_i.size() > 0) check("inst_rdata", inst_rdata, rd_exp_i.pop_front());
                end
                if (data_data_ok) begin
                    check("rd_exp_d_nonempty", rd_exp_d.size() > 0, 1);
                    if (rd_exp_d.size() > 0) check("data_rdata", data_rdata, rd_exp_d.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------ stimulus
    initial begin : stimulus
        wrp_v = 1'b0; wrp_a = 32'd0;
        i_r = '{32'd0, 2'd0, 32'd0}; d_r = '{32'd0, 2'd0, 32'd0};
        m_cur_ar = '{0, 32'd0, 2'd0}; m_cur_req = '{32'd0, 2'd0, 32'd0};
        inst_addr = 32'd0; inst_size = 2'd0; data_addr = 32'd0; data_size = 2'd0;
        wr_pend_valid = 1'b0; wr_pend_addr = 32'd0; rid = 4'd0; rdata = 32'd0;
        model_clear();

        // Reset values, with both requests raised to show addr_ok is held low.
        resetn = 1'b0;
        inst_req = 1'b1; data_req = 1'b1;
        #12;
        check("rst_arvalid", arvalid, 0);
        check("rst_arid", arid, 0);
        check("rst_araddr", araddr, 0);
        check("rst_arsize", arsize, 0);
        check("rst_rready", rready, 0);
        check("rst_inst_addr_ok", inst_addr_ok, 0);
        check("rst_data_addr_ok", data_addr_ok, 0);
        check("rst_inst_data_ok", inst_data_ok, 0);
        check("rst_data_data_ok", data_data_ok, 0);
        inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        check("rready_after_reset", rready, 1);

        // Single inst read
        new_i(32'h1C00_0000, 2'd2, 32'h02C0_0000);
        cycle(1, -1); cycle(1, -1); cycle(1, -1); cycle(1, 0);
        drain();

        // Both requesters at once: data first, inst two cycles later
        new_i(32'h0000_0100, 2'd2, 32'h1111_0000);
        new_d(32'h0000_0200, 2'd2, 32'h2222_0000);
        for (int k = 0; k < 4; k++) cycle(1, -1);
        cycle(1, 1); cycle(1, 0);
        drain();

        // Three data reads without responses: the third waits for a beat
        begin
            int n;
            n = 0;
            for (int k = 0; k < 10; k++) begin
                if (!d_pend && n < 3) begin
                    new_d(32'h0000_3000 + 32'(n * 4), 2'd2, 32'hD000_0000 + 32'(n));
                    n++;
                end
                cycle(1, (k == 6) ? 1 : -1);
            end
        end
        drain();

        // Inst grant together with an rid 0 beat, then a spurious rid 5 beat.
        // Depth filling afterwards shows whether the count is correct.
        new_i(32'h0000_4000, 2'd0, 32'hA000_0001);
        cycle(1, -1); cycle(1, -1);
        new_i(32'h0000_4004, 2'd1, 32'hA000_0002);
        cycle(1, 0); cycle(1, -1);
        cycle(1, 5);
        new_i(32'h0000_4008, 2'd2, 32'hA000_0003);
        cycle(1, -1); cycle(1, -1);
        new_i(32'h0000_400C, 2'd2, 32'hA000_0004);
        cycle(1, -1); cycle(1, -1); cycle(1, -1);
        cycle(1, 0); cycle(1, -1); cycle(1, -1);
        drain();

        // Pending write to the same word as a data read
        wrp_v = 1'b1; wrp_a = 32'h0000_1004;
        new_d(32'h0000_1006, 2'd1, 32'hBEEF_0001);
        new_i(32'h0000_5000, 2'd2, 32'hBEEF_0002);
        for (int k = 0; k < 4; k++) cycle(1, -1);
        wrp_v = 1'b0;
        for (int k = 0; k < 3; k++) cycle(1, -1);
        drain();

        // Asynchronous reset while an AR is stalled
        new_i(32'h0000_6000, 2'd2, 32'hCAFE_0001);
        cycle(0, -1); cycle(0, -1);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check("async_rst_arvalid", arvalid, 0);
        check("async_rst_rready", rready, 0);
        check("async_rst_araddr", araddr, 0);
        model_clear();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        // Both inst reads must be granted if the counts were cleared
        new_i(32'h0000_7000, 2'd2, 32'hCAFE_0002);
        cycle(1, -1); cycle(1, -1);
        new_i(32'h0000_7004, 2'd2, 32'hCAFE_0003);
        cycle(1, -1); cycle(1, -1);
        drain();

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            int rs, pick;
            if (!i_pend && $urandom_range(0, 2) == 0)
                new_i($urandom, 2'($urandom_range(0, 2)), $urandom);
            if (!d_pend && $urandom_range(0, 2) == 0)
                new_d($urandom, 2'($urandom_range(0, 2)), $urandom);
            if ($urandom_range(0, 5) == 0) begin
                wrp_v = $urandom_range(0, 1) == 1;
                wrp_a = {d_r.addr[31:2], 2'($urandom_range(0, 3))};
            end
            pick = $urandom_range(0, 9);
            if (pick < 3)      rs = 0;
            else if (pick < 6) rs = 1;
            else if (pick == 6) rs = 2 + $urandom_range(0, 13);
            else               rs = -1;
            cycle($urandom_range(0, 3) != 0, rs);
        end
        wrp_v = 1'b0;
        drain();

        @(negedge clk); #3;
        check("end_ar_q_empty", ar_q.size(), 0);
        check("end_rd_exp_i_empty", rd_exp_i.size(), 0);
        check("end_rd_exp_d_empty", rd_exp_d.size(), 0);
        check("end_arvalid_idle", arvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
